burst_copy_scheduler: RTL
=========================

// Module: burst_copy_scheduler
// PURPOSE
//  Sequences data_module to copy an arbitrarily long word block from src to dst
//  as a series of AXI bursts. Each burst is at most MAX_BURST words and never
//  crosses a 4 KB boundary on either address. It drives data_module's enable and
//  *_con inputs and reports job completion to the register block.
// PARAMETERS
//  C_registers_DATA_WIDTH  32  width of address/length/flag config words
//  C_data_DATA_WIDTH       32  AXI data width; BPW = C_data_DATA_WIDTH/8 bytes/word
//  MAX_BURST               16  max words per burst, legal 1..256 (arlen/awlen are 8 bit)
// PORTS
//  aclk                      in   1   clock
//  areset                    in   1   synchronous, active-high reset
//  start                     in   1   1-cycle job request; ignored unless idle
//  abort                     in   1   stop after the current burst (sticky until job end)
//  src_addr                  in   CRW job source byte address, BPW-aligned
//  dst_addr                  in   CRW job destination byte address, BPW-aligned
//  word_count                in   CRW job length in words
//  rd_coh / wr_coh           in   CRW coherency flags, passed through unchanged
//  busy                      out  1   job in progress
//  done                      out  1   1-cycle pulse at job end
//  aborted                   out  1   last job ended by abort; cleared on next accepted start
//  bursts_done               out  CRW bursts completed in current/last job
//  enable                    out  1   to data_module
//  read_address_con          out  CRW to data_module
//  write_address_con         out  CRW to data_module
//  burst_length_con          out  CRW to data_module, words
//  read_coherency_flag_con   out  CRW to data_module (= rd_coh latched)
//  write_coherency_flag_con  out  CRW to data_module (= wr_coh latched)
//  read_ready / write_ready  in   1   from data_module, high while its FSM is in READY
// BEHAVIOUR
//  Reset values: every output is 0. The FSM goes to IDLE, and remaining/src/dst are cleared.
//  States: IDLE, PLAN, ISSUE, WAIT, RELEASE, DONE.
//  - IDLE: on start, latch src/dst/word_count/flags, clear bursts_done and aborted,
//    and set busy=1.
//    word_count==0 -> DONE (no enable issued); otherwise -> PLAN.
//  - PLAN: len = min(remaining, MAX_BURST, w4k(src), w4k(dst)), where
//    w4k(a) = (4096 - a[11:0]) / BPW. len is always >= 1.
//    Register len to burst_length_con, and src/dst to read/write_address_con. -> ISSUE.
//  - ISSUE: enable<=1 -> WAIT.
//  - WAIT: hold all *_con stable. When read_ready && write_ready:
//    - enable<=0; src+=len*BPW; dst+=len*BPW; remaining-=len; bursts_done+=1.
//    - -> RELEASE.
//    Only one of the two readys high: keep waiting.
//  - RELEASE: wait for read_ready==0 && write_ready==0 (data_module back in ENABLE).
//    Then: remaining==0 or abort latched -> DONE; otherwise -> PLAN.
//  - DONE: done=1 for exactly one cycle, busy<=0, aborted<=abort latched. -> IDLE.
//  Enable is never reasserted before both readys have dropped. This prevents a
//  stale READY from completing the next burst.
//  Abort in any busy state is latched. The in-flight burst always completes,
//  because data_module cannot be cancelled mid-burst. Abort while IDLE is ignored.
//  Start while busy: ignored, and has no effect on latched parameters.
//  Start and abort in the same IDLE cycle: start is accepted, abort is ignored.
//  Address math is modulo 2^CRW. Address low log2(BPW) bits are treated as zero.
//  Reset mid-job: outputs return to 0 on the next edge. data_module shares areset,
//  since it has no abort path.
//  Per-burst overhead is 4 cycles (PLAN, ISSUE, RELEASE exit, WAIT detect) plus
//  data_module latency.
// CONFIGURATION
//  BURST_SCHED_PERF_EN defined:
//  - Extra output perf_cycles [CRW] counts aclk cycles with busy=1.
//  - It is cleared on an accepted start, frozen at done, and saturates at all-ones.
//  - Reset value is 0.
//  BURST_SCHED_PERF_EN undefined: the port and counter are absent.
//  All other behaviour is identical in both builds.
// TESTING
//  1 MAX_BURST=4, src=0x1000, dst=0x2000, count=10 -> 3 bursts:
//    len 4,4,2; addr 0x1000/0x2000, 0x1010/0x2010, 0x1020/0x2020; done, bursts_done=3.
//  2 MAX_BURST=16, src=0x1FF8, dst=0x3000, count=8 -> bursts len 2 @0x1FF8, len 6 @0x2000/0x3008.
//  3 count=0 -> done pulse within 2 cycles, enable never asserted, bursts_done=0.
//  4 count=12, MAX_BURST=4, abort during burst 1 -> burst 1 completes; no second enable;
//    done with aborted=1, bursts_done=1.
//  5 areset during WAIT -> next cycle enable=0, busy=0, all *_con=0; a new job afterwards completes.
//  6 start pulsed while busy -> ignored. With BURST_SCHED_PERF_EN, perf_cycles equals the
//    busy-high cycle count.

Source files
------------

// File: rtl/burst_copy_scheduler.sv
// burst_copy_scheduler: drives data_module through a long word copy as a series of
// AXI bursts. Each burst holds at most MAX_BURST words and never crosses a 4 KB page
// on either the source or the destination address.
// Optional build macro BURST_SCHED_PERF_EN adds the perf_cycles busy-cycle counter.
module burst_copy_scheduler #(
   parameter int C_registers_DATA_WIDTH = 32,
   parameter int C_data_DATA_WIDTH      = 32,
   parameter int MAX_BURST              = 16
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic                              start,
   input  logic                              abort,
   input  logic [C_registers_DATA_WIDTH-1:0] src_addr,
   input  logic [C_registers_DATA_WIDTH-1:0] dst_addr,
   input  logic [C_registers_DATA_WIDTH-1:0] word_count,
   input  logic [C_registers_DATA_WIDTH-1:0] rd_coh,
   input  logic [C_registers_DATA_WIDTH-1:0] wr_coh,
   output logic                              busy,
   output logic                              done,
   output logic                              aborted,
   output logic [C_registers_DATA_WIDTH-1:0] bursts_done,
   output logic                              enable,
   output logic [C_registers_DATA_WIDTH-1:0] read_address_con,
   output logic [C_registers_DATA_WIDTH-1:0] write_address_con,
   output logic [C_registers_DATA_WIDTH-1:0] burst_length_con,
   output logic [C_registers_DATA_WIDTH-1:0] read_coherency_flag_con,
   output logic [C_registers_DATA_WIDTH-1:0] write_coherency_flag_con,
`ifdef BURST_SCHED_PERF_EN
   output logic [C_registers_DATA_WIDTH-1:0] perf_cycles,
`endif
   input  logic                              read_ready,
   input  logic                              write_ready
);

   localparam int CRW     = C_registers_DATA_WIDTH;
   localparam int BPW     = C_data_DATA_WIDTH / 8;
   localparam int BPW_LOG = $clog2(BPW);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PLAN    = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   // Byte addresses are word addresses in disguise; sub-word bits are dropped.
   localparam logic [CRW-1:0] ALIGN_MASK = ~(CRW'(BPW - 1));

   logic [2:0]     r_state;
   logic [CRW-1:0] r_src, r_dst, r_remaining;
   logic [CRW-1:0] r_rd_addr, r_wr_addr, r_burst_len;
   logic [CRW-1:0] r_rd_coh, r_wr_coh, r_bursts_done;
   logic           r_busy, r_enable, r_aborted, r_abort;

   logic [12:0]    w_w4k_src, w_w4k_dst;
   logic [CRW-1:0] w_len, w_step;
   logic           w_abort_any;

   // Burst length: the smallest of words left, MAX_BURST and room left in both 4 KB pages.
   always_comb begin
      w_w4k_src = (13'd4096 - {1'b0, r_src[11:0]}) >> BPW_LOG;
      w_w4k_dst = (13'd4096 - {1'b0, r_dst[11:0]}) >> BPW_LOG;
      w_len     = r_remaining;
      if (w_len > CRW'(MAX_BURST)) w_len = CRW'(MAX_BURST);
      if (w_len > CRW'(w_w4k_src)) w_len = CRW'(w_w4k_src);
      if (w_len > CRW'(w_w4k_dst)) w_len = CRW'(w_w4k_dst);
   end

   assign w_step      = r_burst_len << BPW_LOG;
   // An abort arriving in the deciding cycle still stops the job after this burst.
   assign w_abort_any = r_abort | abort;

   // Job sequencing FSM and all registered outputs.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state       <= S_IDLE;
         r_src         <= '0;
         r_dst         <= '0;
         r_remaining   <= '0;
         r_rd_addr     <= '0;
         r_wr_addr     <= '0;
         r_burst_len   <= '0;
         r_rd_coh      <= '0;
         r_wr_coh      <= '0;
         r_bursts_done <= '0;
         r_busy        <= 1'b0;
         r_enable      <= 1'b0;
         r_aborted     <= 1'b0;
         r_abort       <= 1'b0;
      end else begin
         if (r_busy && abort) r_abort <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src         <= src_addr & ALIGN_MASK;
                  r_dst         <= dst_addr & ALIGN_MASK;
                  r_remaining   <= word_count;
                  r_rd_coh      <= rd_coh;
                  r_wr_coh      <= wr_coh;
                  r_bursts_done <= '0;
                  r_aborted     <= 1'b0;
                  r_abort       <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= (word_count == '0) ? S_DONE : S_PLAN;
               end
            end
            S_PLAN: begin
               r_burst_len <= w_len;
               r_rd_addr   <= r_src;
               r_wr_addr   <= r_dst;
               r_state     <= S_ISSUE;
            end
            S_ISSUE: begin
               r_enable <= 1'b1;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               // Both sides must be done; a lone ready means the other channel lags.
               if (read_ready && write_ready) begin
                  r_enable      <= 1'b0;
                  r_src         <= r_src + w_step;
                  r_dst         <= r_dst + w_step;
                  r_remaining   <= r_remaining - r_burst_len;
                  r_bursts_done <= r_bursts_done + 1'b1;
                  r_state       <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               // A stale READY must clear before the next enable, or it would
               // complete the following burst instantly.
               if (!read_ready && !write_ready) begin
                  r_state <= ((r_remaining == '0) || w_abort_any) ? S_DONE : S_PLAN;
               end
            end
            S_DONE: begin
               r_busy    <= 1'b0;
               r_aborted <= w_abort_any;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef BURST_SCHED_PERF_EN
   logic [CRW-1:0] r_perf;

   // Busy-cycle counter: cleared by an accepted start, saturating, naturally frozen once idle.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_perf <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_perf <= '0;
      end else if (r_busy && (r_perf != '1)) begin
         r_perf <= r_perf + 1'b1;
      end
   end

   assign perf_cycles = r_perf;
`else
   // No performance counter in this build.
`endif

   assign busy                     = r_busy;
   assign done                     = (r_state == S_DONE);
   assign aborted                  = r_aborted;
   assign bursts_done              = r_bursts_done;
   assign enable                   = r_enable;
   assign read_address_con         = r_rd_addr;
   assign write_address_con        = r_wr_addr;
   assign burst_length_con         = r_burst_len;
   assign read_coherency_flag_con  = r_rd_coh;
   assign write_coherency_flag_con = r_wr_coh;

endmodule
